// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX-stage decoder and the divider.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start_div;
    logic [1:0]      div_func;
    logic            flush;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_div, div_func, flush, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start_div, div_func, flush, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// div_func: 00 div, 01 divu, 10 rem, 11 remu.
module div_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    state_e               state;
    logic [1:0]           func;
    logic [CNT_WIDTH-1:0] cnt;
    logic [XLEN-1:0]      rem;
    logic [XLEN-1:0]      quo;
    logic [XLEN-1:0]      dvsr;
    logic                 q_neg;
    logic                 r_neg;
    logic                 busy_r;
    logic                 done_r;
    logic [XLEN-1:0]      result_r;

    logic                 is_signed;
    logic [XLEN-1:0]      a_abs;
    logic [XLEN-1:0]      b_abs;
    logic [XLEN:0]        rem_sh;
    logic [XLEN:0]        rem_diff;
    logic [XLEN-1:0]      rem_next;
    logic [XLEN-1:0]      quo_next;

    // Select quotient or remainder and apply the recorded sign.
    function automatic logic [XLEN-1:0] pick_result(input logic [1:0] f,
                                                    input logic [XLEN-1:0] q,
                                                    input logic [XLEN-1:0] r,
                                                    input logic qn,
                                                    input logic rn);
        logic [XLEN-1:0] v;
        logic            neg;
        if (f[1]) begin
            v   = r;
            neg = rn;
        end else begin
            v   = q;
            neg = qn;
        end
        if (neg && !f[0]) v = -v;
        return v;
    endfunction

    // Operand magnitudes for signed ops, taken at the accepting edge.
    always_comb begin
        is_signed = ~bus.div_func[0];
        a_abs     = bus.dividend[XLEN-1] ? -bus.dividend : bus.dividend;
        b_abs     = bus.divisor[XLEN-1] ? -bus.divisor : bus.divisor;
    end

    // One restoring step; the shifted remainder is XLEN+1 wide and the borrow decides.
    always_comb begin
        rem_sh   = {rem, quo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        quo_next = {quo[XLEN-2:0], ~rem_diff[XLEN]};
        rem_next = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
    end

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            func     <= '0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    done_r <= 1'b0;
                    if (bus.start_div && !bus.flush) begin
                        func   <= bus.div_func;
                        busy_r <= 1'b1;
                        if (bus.divisor == '0) begin
                            state    <= StDone;
                            done_r   <= 1'b1;
                            result_r <= pick_result(bus.div_func, '1, bus.dividend, 1'b0, 1'b0);
                        end else if (is_signed && bus.dividend == MinInt && bus.divisor == '1) begin
                            state    <= StDone;
                            done_r   <= 1'b1;
                            result_r <= pick_result(bus.div_func, MinInt, '0, 1'b0, 1'b0);
                        end else begin
                            state <= StCalc;
                            cnt   <= CNT_WIDTH'(XLEN);
                            rem   <= '0;
                            quo   <= is_signed ? a_abs : bus.dividend;
                            dvsr  <= is_signed ? b_abs : bus.divisor;
                            q_neg <= is_signed & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                            r_neg <= is_signed & bus.dividend[XLEN-1];
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state  <= StIdle;
                        busy_r <= 1'b0;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt - CNT_WIDTH'(1);
                        if (cnt == CNT_WIDTH'(1)) begin
                            state    <= StDone;
                            done_r   <= 1'b1;
                            result_r <= pick_result(func, quo_next, rem_next, q_neg, r_neg);
                        end
                    end
                end
                StDone: begin
                    state  <= StIdle;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= StIdle;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing in the DONE cycle suppresses the pulse.
    assign bus.busy   = busy_r;
    assign bus.done   = done_r & ~bus.flush;
    assign bus.result = result_r;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expectations, monitor pops on done.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_unit_if #(.XLEN(32)) dif ();

    div_unit #(.XLEN(32), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dif.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got result %h, required no done", dif.result);
            end else begin
                e = sb.pop_front();
                check(e.name, dif.result, e.res);
                check({e.name, "_latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        dif.start_div = 1'b1;
        dif.div_func  = f;
        dif.dividend  = a;
        dif.divisor   = b;
        e.name = name;
        e.res  = r;
        e.lat  = lat;
        e.t0   = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        sb.delete();
    endtask

    task automatic pulse_start(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        dif.start_div = 1'b1;
        dif.div_func  = f;
        dif.dividend  = a;
        dif.divisor   = b;
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n0;
        dif.start_div = 1'b0;
        dif.div_func  = 2'b00;
        dif.flush     = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", dif.busy, 0);
        check("reset_done", dif.done, 0);
        check("reset_result", dif.result, 32'h0);
        rst = 1'b0;

        // Normal path, unsigned and signed
        issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);        drain();
        issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);         drain();
        issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33); drain();
        issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33); drain();
        issue("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);     drain();
        issue("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33); drain();
        issue("rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33); drain();
        issue("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33); drain();

        // Divide by zero fast path
        issue("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);      drain();
        issue("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1);              drain();
        issue("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);       drain();
        issue("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1); drain();

        // Signed overflow fast path; unsigned takes the full path
        issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); drain();
        issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1); drain();
        issue("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33); drain();
        issue("remu_ovf_ops", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33); drain();

        // Start while busy is ignored
        n0 = n_done;
        issue("divu_busy_ignore", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        repeat (8) @(posedge clk);
        pulse_start(2'b01, 32'd9, 32'd3);
        check("busy_during_calc", dif.busy, 1);
        drain();
        repeat (40) @(posedge clk);
        check("single_done", n_done - n0, 1);

        // Flush mid-calculation
        n0 = n_done;
        pulse_start(2'b00, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        dif.flush = 1'b1;
        @(posedge clk);
        #1;
        dif.flush = 1'b0;
        check("flush_busy", dif.busy, 0);
        repeat (40) @(posedge clk);
        check("flush_no_done", n_done - n0, 0);
        issue("divu_after_flush", 2'b01, 32'd9, 32'd3, 32'd3, 33); drain();

        // Reset mid-calculation
        n0 = n_done;
        pulse_start(2'b00, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", dif.busy, 0);
        check("rst_result", dif.result, 32'h0);
        repeat (40) @(posedge clk);
        check("rst_no_done", n_done - n0, 0);
        issue("divu_after_rst", 2'b01, 32'd9, 32'd3, 32'd3, 33); drain();

        // Flush together with start in IDLE
        n0 = n_done;
        @(posedge clk);
        #1;
        dif.start_div = 1'b1;
        dif.flush     = 1'b1;
        dif.div_func  = 2'b01;
        dif.dividend  = 32'd9;
        dif.divisor   = 32'd3;
        @(posedge clk);
        #1;
        dif.start_div = 1'b0;
        dif.flush     = 1'b0;
        check("start_flush_busy", dif.busy, 0);
        repeat (40) @(posedge clk);
        check("start_flush_no_done", n_done - n0, 0);
        check("result_held", dif.result, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
